dmem_ctrl: RTL and testbench

//  Data-memory controller between the MIPS core's load/store port and the 4096x32 word RAM.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_lane_unit.sv | 41 ++++
 rtl/dmem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// MMIO addresses are only decoded when DMEM_MMIO_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MRG,
    WR,
    RESP
  } state_e;

  localparam logic [31:0] MMIO_LED_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_SW_ADDR  = 32'hFFFF_0004;

  // Size code 2'b11 behaves as a word access.
  function automatic size_e decode_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and extends load data, and merges
// byte/half store data into a RAM word.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] ram_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = ram_word[{addr_lo, 3'b000} +: 8];
    half_v    = ram_word[{addr_lo[1], 4'b0000} +: 16];
    load_data = ram_word;
    merged    = store_data;
    unique case (size)
      SZ_B: begin
        load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
        merged    = ram_word;
        merged[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      end
      SZ_H: begin
        load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
        merged    = ram_word;
        merged[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: begin
        load_data = ram_word;
        merged    = store_data;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-addressed loads/stores onto a word RAM, with
// read-modify-write for sub-word stores. Optional MMIO via DMEM_MMIO_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          stall,
  output logic [31:0]   rdata,
  output logic          rdata_valid,
  output logic          misalign,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic          ram_wren,
  input  logic [31:0]   ram_rdata
`ifdef DMEM_MMIO_EN
  ,
  output logic [15:0]   led_out,
  input  logic [15:0]   sw_in
`endif
);

  state_e        state_q, state_d;
  size_e         size_q, size_d, size_v;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic          unsigned_q, unsigned_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic [31:0]   load_data, merged;
  logic          done;
`ifdef DMEM_MMIO_EN
  logic          mmio_q, mmio_d;
  logic [15:0]   sw_q, sw_d, led_q, led_d;
`else
  logic          unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];
`endif

  dmem_lane_unit u_lane (
    .size        (size_q),
    .addr_lo     (addr_lo_q),
    .is_unsigned (unsigned_q),
    .ram_word    (ram_rdata),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    unsigned_d  = unsigned_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    size_v      = decode_size(req_size);
    done        = 1'b0;
    misalign    = 1'b0;
    rdata       = '0;
    rdata_valid = 1'b0;
`ifdef DMEM_MMIO_EN
    mmio_d      = mmio_q;
    sw_d        = sw_q;
    led_d       = led_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef DMEM_MMIO_EN
          if (req_addr[31:16] == 16'hFFFF) begin
            done = 1'b1;
            if (req_we && (size_v == SZ_W) && (req_addr == MMIO_LED_ADDR)) begin
              led_d = req_wdata[15:0];
            end else if (!req_we && (size_v == SZ_W) && (req_addr == MMIO_SW_ADDR)) begin
              done    = 1'b0;
              mmio_d  = 1'b1;
              sw_d    = sw_in;
              state_d = RESP;
            end else begin
              misalign = 1'b1;
            end
          end else
`endif
          if (is_misaligned(size_v, req_addr[1:0])) begin
            done     = 1'b1;
            misalign = 1'b1;
          end else begin
            size_d     = size_v;
            addr_lo_d  = req_addr[1:0];
            unsigned_d = req_unsigned;
            we_d       = req_we;
            wdata_d    = req_wdata;
            ram_addr_d = req_addr[AW+1:2];
`ifdef DMEM_MMIO_EN
            mmio_d     = 1'b0;
`endif
            if (req_we && (size_v == SZ_W)) begin
              ram_wdata_d = req_wdata;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      // RAM samples ram_addr at the end of this cycle.
      RD:   state_d = we_q ? MRG : RESP;
      MRG: begin
        ram_wdata_d = merged;
        state_d     = WR;
      end
      WR: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      RESP: begin
        done        = 1'b1;
        rdata_valid = 1'b1;
`ifdef DMEM_MMIO_EN
        rdata       = mmio_q ? {16'h0000, sw_q} : load_data;
`else
        rdata       = load_data;
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      size_q      <= SZ_B;
      addr_lo_q   <= '0;
      unsigned_q  <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifdef DMEM_MMIO_EN
      mmio_q      <= 1'b0;
      sw_q        <= '0;
      led_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      unsigned_q  <= unsigned_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef DMEM_MMIO_EN
      mmio_q      <= mmio_d;
      sw_q        <= sw_d;
      led_q       <= led_d;
`endif
    end
  end

  assign stall     = req_valid & ~done;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wren  = (state_q == WR);
`ifdef DMEM_MMIO_EN
  assign led_out   = led_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: drivers push expected RAM writes, load
// results and misalign pulses; a negedge monitor pops and compares.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned AW = 12;
  localparam int KLoad = 0;
  localparam int KWrite = 1;
  localparam int KMis = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          stall, rdata_valid, misalign, ram_wren;
  logic [31:0]   rdata, ram_wdata;
  logic [31:0]   ram_rdata = '0;
  logic [AW-1:0] ram_addr;
`ifdef DMEM_MMIO_EN
  logic [15:0]   led_out;
  logic [15:0]   sw_in = 16'h0000;
`endif

  logic [31:0] mem [4096];
  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;

  dmem_ctrl #(.AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .misalign     (misalign),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wren     (ram_wren),
    .ram_rdata    (ram_rdata)
`ifdef DMEM_MMIO_EN
    ,
    .led_out      (led_out),
    .sw_in        (sw_in)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int kind, input string name, input logic [31:0] act,
                         input logic [31:0] aaddr);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s actual=%h expected=none", name, act);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_data"}, act, e.data);
      if (kind == KWrite) chk({name, "_addr"}, aaddr, e.addr);
    end
  endtask

  always @(negedge clk) begin
    if (ram_wren) pop_chk(KWrite, "ram_write", ram_wdata, 32'(ram_addr));
    if (rdata_valid) pop_chk(KLoad, "load", rdata, '0);
    if (misalign) pop_chk(KMis, "misalign", 32'd0, '0);
    if (!rdata_valid && rdata !== 32'h0) chk("rdata_idle_zero", rdata, 32'h0);
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, output int cycles);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cycles++;
      if (!stall) break;
    end
    if (stall) chk("req_timeout", 32'(stall), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic load(input string name, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp, input int lat);
    int c;
    sb_q.push_back('{kind: KLoad, data: exp, addr: 32'h0});
    do_req(1'b0, sz, uns, addr, 32'h0, c);
    chk({name, "_latency"}, c, lat);
  endtask

  task automatic store(input string name, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_word, input int lat);
    int c;
    sb_q.push_back('{kind: KWrite, data: exp_word, addr: 32'(addr[AW+1:2])});
    do_req(1'b1, sz, 1'b0, addr, wd, c);
    chk({name, "_latency"}, c, lat);
    chk({name, "_ram"}, mem[addr[AW+1:2]], exp_word);
  endtask

  task automatic mis(input string name, input logic we, input logic [1:0] sz,
                     input logic [31:0] addr);
    int c;
    sb_q.push_back('{kind: KMis, data: 32'h0, addr: 32'h0});
    do_req(we, sz, 1'b0, addr, 32'hDEAD_BEEF, c);
    chk({name, "_latency"}, c, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h0101_0101;
    mem[4] = 32'h8899_AABB;
    mem[8] = 32'h1122_3344;

    #12;
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_ram_wren", 32'(ram_wren), 32'h0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    load("lw_10", 2'b10, 1'b0, 32'h10, 32'h8899_AABB, 3);
    load("lb_13", 2'b00, 1'b0, 32'h13, 32'hFFFF_FF88, 3);
    load("lbu_13", 2'b00, 1'b1, 32'h13, 32'h0000_0088, 3);
    load("lh_12", 2'b01, 1'b0, 32'h12, 32'hFFFF_8899, 3);
    load("lhu_10", 2'b01, 1'b1, 32'h10, 32'h0000_AABB, 3);
    load("lh_10", 2'b01, 1'b0, 32'h10, 32'hFFFF_AABB, 3);
    store("sb_11", 2'b00, 32'h11, 32'h0000_005A, 32'h8899_5ABB, 4);
    load("lw11_after_sb", 2'b11, 1'b0, 32'h10, 32'h8899_5ABB, 3);
    store("sw_40", 2'b10, 32'h40, 32'hCAFE_F00D, 32'hCAFE_F00D, 2);
    store("sh_42", 2'b01, 32'h42, 32'h1234_7EEF, 32'h7EEF_F00D, 4);
    load("lb_41", 2'b00, 1'b0, 32'h41, 32'hFFFF_FFF0, 3);
    load("lw_40", 2'b10, 1'b0, 32'h40, 32'h7EEF_F00D, 3);
    mis("lw_0a", 1'b0, 2'b10, 32'h0A);
    mis("sh_03", 1'b1, 2'b01, 32'h03);

    // Reset lands while the SH read-modify-write is in MRG.
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("abort_state_idle", 32'(dut.state_q == IDLE), 32'h1);
    chk("abort_ram_wren", 32'(ram_wren), 32'h0);
    chk("abort_ram_wdata", ram_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_ram_word", mem[8], 32'h1122_3344);
    load("lw_20_after_abort", 2'b10, 1'b0, 32'h20, 32'h1122_3344, 3);

`ifdef DMEM_MMIO_EN
    begin
      int c;
      do_req(1'b1, 2'b10, 1'b0, MMIO_LED_ADDR, 32'h0000_1234, c);
      chk("mmio_led_latency", c, 1);
      chk("mmio_led_out", 32'(led_out), 32'h0000_1234);
      sw_in = 16'h00A5;
      load("mmio_sw", 2'b10, 1'b0, MMIO_SW_ADDR, 32'h0000_00A5, 2);
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
